// File: rtl/diff_sq_inverter_if.sv
// Handshake conduits of diff_sq_inverter: R/B request in, recovered A out.
interface diff_sq_inverter_if #(
    parameter int N = 32
);
    logic [N-1:0] coe_R;
    logic [N-1:0] coe_B;
    logic         coe_in_valid;
    logic         coe_in_ready;
    logic [N-1:0] coe_A;
    logic         coe_exact;
    logic         coe_out_valid;
    logic         coe_out_ready;

    modport master (
        output coe_R, coe_B, coe_in_valid, coe_out_ready,
        input  coe_in_ready, coe_A, coe_exact, coe_out_valid
    );

    modport slave (
        input  coe_R, coe_B, coe_in_valid, coe_out_ready,
        output coe_in_ready, coe_A, coe_exact, coe_out_valid
    );
endinterface

// File: rtl/diff_sq_inverter.sv
// Recovers A = floor(sqrt(R + B*B)) with a bit-serial restoring square root,
// one result bit per clock.
module diff_sq_inverter #(
    parameter int N = 32
) (
    input  logic              csi_clk,
    input  logic              rsi_srst_n,
    diff_sq_inverter_if.slave bus
);
    localparam int CW = $clog2(N);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_SQ   = 2'd1;
    localparam logic [1:0] ST_ROOT = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    localparam logic [CW-1:0] CNT_TOP = CW'(N - 1);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);

    logic [1:0]     state_q;
    logic [N-1:0]   r_q;
    logic [N-1:0]   b_q;
    logic [2*N-1:0] s_q;
    logic [N+1:0]   rem_q;
    logic [N-1:0]   root_q;
    logic [CW-1:0]  cnt_q;
    logic [N-1:0]   a_q;
    logic           exact_q;

    logic [2*N-1:0] b_wide;
    logic [2*N-1:0] s_nx;
    logic [1:0]     pair;
    logic [N+1:0]   rem_sh;
    logic [N+1:0]   trial;
    logic           take;
    logic [N+1:0]   rem_nx;
    logic [N-1:0]   root_nx;

    // Full 2N-bit square: R + B*B never exceeds 2^2N - 2^N, so no carry is lost.
    always_comb begin
        b_wide = {{N{1'b0}}, b_q};
        s_nx   = {{N{1'b0}}, r_q} + b_wide * b_wide;
    end

    // One restoring step: bring down the next bit pair and try to subtract 4*root+1.
    always_comb begin
        pair    = s_q[{cnt_q, 1'b0} +: 2];
        rem_sh  = (rem_q << 2) | {{N{1'b0}}, pair};
        trial   = ({2'b00, root_q} << 2) | {{(N+1){1'b0}}, 1'b1};
        take    = (rem_sh >= trial);
        rem_nx  = take ? (rem_sh - trial) : rem_sh;
        root_nx = (root_q << 1) | {{(N-1){1'b0}}, take};
    end

    always_ff @(posedge csi_clk) begin
        if (!rsi_srst_n) begin
            state_q <= ST_IDLE;
            r_q     <= '0;
            b_q     <= '0;
            s_q     <= '0;
            rem_q   <= '0;
            root_q  <= '0;
            cnt_q   <= '0;
            a_q     <= '0;
            exact_q <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (bus.coe_in_valid) begin
                        r_q     <= bus.coe_R;
                        b_q     <= bus.coe_B;
                        state_q <= ST_SQ;
                    end
                end
                ST_SQ: begin
                    s_q     <= s_nx;
                    rem_q   <= '0;
                    root_q  <= '0;
                    cnt_q   <= CNT_TOP;
                    state_q <= ST_ROOT;
                end
                ST_ROOT: begin
                    rem_q  <= rem_nx;
                    root_q <= root_nx;
                    cnt_q  <= cnt_q - CNT_ONE;
                    // Results are latched here so they only move on entry to DONE.
                    if (cnt_q == '0) begin
                        a_q     <= root_nx;
                        exact_q <= (rem_nx == '0);
                        state_q <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (bus.coe_out_ready) begin
                        state_q <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign bus.coe_in_ready  = (state_q == ST_IDLE);
    assign bus.coe_out_valid = (state_q == ST_DONE);
    assign bus.coe_A         = a_q;
    assign bus.coe_exact     = exact_q;
endmodule

// File: tb/tb_diff_sq_inverter.sv
// Self-checking bench for diff_sq_inverter: directed table, corner sequences
// and random pairs against an integer square-root model.
module tb_diff_sq_inverter;
    localparam int N   = 32;
    localparam int LAT = N + 1;

    logic clk;
    logic srst_n;
    int   n_cmp;
    int   n_err;

    diff_sq_inverter_if #(.N(N)) bus ();

    diff_sq_inverter #(.N(N)) dut (
        .csi_clk    (clk),
        .rsi_srst_n (srst_n),
        .bus        (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [N-1:0] r;
        logic [N-1:0] b;
        logic [N-1:0] a;
        logic         ex;
    } vec_t;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Greedy bit-by-bit search for the largest a with a*a <= R + B*B.
    function automatic void model(input logic [N-1:0] r, input logic [N-1:0] b,
                                  output logic [N-1:0] a, output logic ex);
        logic [63:0] s;
        logic [N-1:0] cand;
        s = {32'h0, r} + {32'h0, b} * {32'h0, b};
        a = '0;
        for (int i = N - 1; i >= 0; i--) begin
            cand = a | (32'h1 << i);
            if ({32'h0, cand} * {32'h0, cand} <= s) a = cand;
        end
        ex = ({32'h0, a} * {32'h0, a} == s);
    endfunction

    // Present a pair from an idle DUT and wait (bounded) for coe_out_valid.
    task automatic start_txn(input logic [N-1:0] r, input logic [N-1:0] b, input string nm);
        int  lat;
        bit  busy_ok;
        chk({nm, " in_ready before accept"}, 64'(bus.coe_in_ready), 64'd1);
        bus.coe_R        = r;
        bus.coe_B        = b;
        bus.coe_in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.coe_in_valid = 1'b0;
        bus.coe_R        = $urandom;
        bus.coe_B        = $urandom;
        lat     = 0;
        busy_ok = 1'b1;
        while (!bus.coe_out_valid && lat < 200) begin
            if (bus.coe_in_ready !== 1'b0) busy_ok = 1'b0;
            @(posedge clk);
            @(negedge clk);
            lat++;
        end
        chk({nm, " in_ready low while busy"}, 64'(busy_ok), 64'd1);
        chk({nm, " latency"}, 64'(lat), 64'(LAT));
        chk({nm, " in_ready low in DONE"}, 64'(bus.coe_in_ready), 64'd0);
    endtask

    task automatic consume(input string nm);
        bus.coe_out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.coe_out_ready = 1'b0;
        chk({nm, " out_valid drops"}, 64'(bus.coe_out_valid), 64'd0);
        chk({nm, " back to idle"}, 64'(bus.coe_in_ready), 64'd1);
    endtask

    initial begin
        vec_t         tbl[9];
        logic [N-1:0] r, b, ea;
        logic         ee;
        bit           stable, saw_valid;

        n_cmp = 0;
        n_err = 0;
        bus.coe_R         = '0;
        bus.coe_B         = '0;
        bus.coe_in_valid  = 1'b0;
        bus.coe_out_ready = 1'b0;
        srst_n            = 1'b0;

        tbl[0] = '{r: 32'd16, b: 32'd3, a: 32'd5, ex: 1'b1};
        tbl[1] = '{r: 32'd10, b: 32'd0, a: 32'd3, ex: 1'b0};
        tbl[2] = '{r: 32'd0,  b: 32'd7, a: 32'd7, ex: 1'b1};
        tbl[3] = '{r: 32'd0,  b: 32'd0, a: 32'd0, ex: 1'b1};
        tbl[4] = '{r: 32'hFFFFFFFF, b: 32'hFFFFFFFF, a: 32'hFFFFFFFF, ex: 1'b0};
        tbl[5] = '{r: 32'd0,  b: 32'hFFFFFFFF, a: 32'hFFFFFFFF, ex: 1'b1};
        tbl[6] = '{r: 32'd21, b: 32'd2, a: 32'd5, ex: 1'b1};
        tbl[7] = '{r: 32'd24, b: 32'd0, a: 32'd4, ex: 1'b0};
        tbl[8] = '{r: 32'd1,  b: 32'd0, a: 32'd1, ex: 1'b1};

        // Reset held for 3 cycles
        repeat (3) @(posedge clk);
        @(negedge clk);
        srst_n = 1'b1;
        @(negedge clk);
        chk("reset out_valid", 64'(bus.coe_out_valid), 64'd0);
        chk("reset A", 64'(bus.coe_A), 64'd0);
        chk("reset exact", 64'(bus.coe_exact), 64'd0);
        chk("reset in_ready", 64'(bus.coe_in_ready), 64'd1);

        for (int i = 0; i < 9; i++) begin
            start_txn(tbl[i].r, tbl[i].b, $sformatf("vec%0d", i));
            chk($sformatf("vec%0d A", i), 64'(bus.coe_A), 64'(tbl[i].a));
            chk($sformatf("vec%0d exact", i), 64'(bus.coe_exact), 64'(tbl[i].ex));
            consume($sformatf("vec%0d", i));
        end

        // Backpressure with busy-side input churn
        start_txn(32'd16, 32'd3, "bp");
        stable = 1'b1;
        for (int i = 0; i < 10; i++) begin
            bus.coe_R        = $urandom;
            bus.coe_B        = $urandom;
            bus.coe_in_valid = (i % 2 == 0);
            @(posedge clk);
            @(negedge clk);
            if (bus.coe_A !== 32'd5 || bus.coe_exact !== 1'b1 ||
                bus.coe_out_valid !== 1'b1 || bus.coe_in_ready !== 1'b0)
                stable = 1'b0;
        end
        chk("bp outputs held", 64'(stable), 64'd1);
        bus.coe_R        = 32'd21;
        bus.coe_B        = 32'd2;
        bus.coe_in_valid = 1'b1;
        consume("bp");
        start_txn(32'd21, 32'd2, "bp next");
        chk("bp next A", 64'(bus.coe_A), 64'd5);
        chk("bp next exact", 64'(bus.coe_exact), 64'd1);
        consume("bp next");

        // Reset at edge 10 of a computation
        bus.coe_R        = 32'd1000;
        bus.coe_B        = 32'd77;
        bus.coe_in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.coe_in_valid = 1'b0;
        repeat (9) begin
            @(posedge clk);
            @(negedge clk);
        end
        srst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("midrst out_valid", 64'(bus.coe_out_valid), 64'd0);
        chk("midrst A", 64'(bus.coe_A), 64'd0);
        chk("midrst exact", 64'(bus.coe_exact), 64'd0);
        srst_n = 1'b1;
        saw_valid = 1'b0;
        repeat (40) begin
            @(posedge clk);
            @(negedge clk);
            if (bus.coe_out_valid !== 1'b0) saw_valid = 1'b1;
        end
        chk("midrst no output", 64'(saw_valid), 64'd0);
        start_txn(32'd21, 32'd2, "post rst");
        chk("post rst A", 64'(bus.coe_A), 64'd5);
        chk("post rst exact", 64'(bus.coe_exact), 64'd1);
        consume("post rst");

        // Random pairs: full range and small values (more perfect squares)
        for (int i = 0; i < 30; i++) begin
            if (i % 3 == 0) begin
                r = $urandom_range(0, 200);
                b = $urandom_range(0, 50);
            end else begin
                r = $urandom;
                b = $urandom;
            end
            model(r, b, ea, ee);
            start_txn(r, b, $sformatf("rnd%0d", i));
            chk($sformatf("rnd%0d A", i), 64'(bus.coe_A), 64'(ea));
            chk($sformatf("rnd%0d exact", i), 64'(bus.coe_exact), 64'(ee));
            consume($sformatf("rnd%0d", i));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end
endmodule
